// File: rtl/physics_sequencer_pkg.sv
// Shared types for the frame physics sequencer: FSM states, hit flag layout and defaults.
// Pure declarations; no latency or flow-control behaviour of its own.
package physics_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    NEXT = 2'd2
  } seq_state_t;

  // Bit positions inside a hit_t result word.
  localparam int HIT_LEFT     = 4;
  localparam int HIT_RIGHT    = 3;
  localparam int HIT_TOP      = 2;
  localparam int HIT_BOTTOM   = 1;
  localparam int HIT_GROUNDED = 0;

  typedef logic [4:0] hit_t;

  localparam int N_PLAT_DEF = 4;

endpackage

// File: rtl/physics_sequencer_if.sv
// Request/ack link between the sequencer (master) and the shared collision checker (slave).
// No latency; chk_player/plat_idx are held by the master while chk_req is high.
interface physics_sequencer_if #(
  parameter int IDX_W = 4
);
  import physics_sequencer_pkg::*;

  logic             chk_req;
  logic             chk_player;
  logic [IDX_W-1:0] plat_idx;
  logic             chk_ack;
  hit_t             chk_hit;

  modport master (
    output chk_req, chk_player, plat_idx,
    input  chk_ack, chk_hit
  );

  modport slave (
    input  chk_req, chk_player, plat_idx,
    output chk_ack, chk_hit
  );

endinterface

// File: rtl/physics_sequencer_seq_watchdog.sv
// Counts unanswered request cycles; expire_o fires combinationally on the TIMEOUT-th one.
// Counter clears whenever clear_i is high or on expiry, so each request gets a fresh budget.
module physics_sequencer_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = wait_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/physics_sequencer.sv
// Per-frame scheduler sharing one collision checker between two players; publishes OR-ed flags.
// First chk_req one cycle after frame_tick; each request waits for chk_ack or times out.
module physics_sequencer
  import physics_sequencer_pkg::*;
#(
  parameter int N_PLAT  = N_PLAT_DEF,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick_i,
  input  logic                clr_err_i,
  physics_sequencer_if.master chk,
  output hit_t                col_p0_o,
  output hit_t                col_p1_o,
  output logic [1:0]          update_p_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                chk_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAT - 1);

  seq_state_t       state_q;
  logic             req_q;
  logic             player_q;
  logic             fin_q;
  logic [IDX_W-1:0] idx_q;
  hit_t             acc_q;
  hit_t             col0_q;
  hit_t             col1_q;
  logic [1:0]       upd_q;
  logic             ovr_q;
  logic             err_q;

  logic in_req;
  logic ack;
  logic expire;
  logic done;
  hit_t acc_nx;

  assign in_req = (state_q == REQ);
  assign ack    = in_req && chk.chk_ack;
  assign done   = ack || expire;
  // A timed-out request contributes nothing to the accumulator.
  assign acc_nx = acc_q | (ack ? chk.chk_hit : '0);

  physics_sequencer_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (!in_req || chk.chk_ack),
    .wait_i   (in_req && !chk.chk_ack),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      player_q <= 1'b0;
      fin_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      col0_q   <= '0;
      col1_q   <= '0;
      upd_q    <= '0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upd_q <= '0;
      // Clear first so a same-cycle set event wins.
      if (clr_err_i) begin
        ovr_q <= 1'b0;
        err_q <= 1'b0;
      end
      if (frame_tick_i && (state_q != IDLE)) ovr_q <= 1'b1;
      if (expire) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_tick_i) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            player_q <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            fin_q    <= 1'b0;
          end
        end
        REQ: begin
          if (done) begin
            state_q <= NEXT;
            req_q   <= 1'b0;
            if (idx_q == LAST_IDX) begin
              if (player_q) col1_q <= acc_nx;
              else          col0_q <= acc_nx;
              upd_q[player_q] <= 1'b1;
              fin_q    <= player_q;
              player_q <= ~player_q;
              idx_q    <= '0;
              acc_q    <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
              acc_q <= acc_nx;
            end
          end
        end
        NEXT: begin
          if (fin_q) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
          end else begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign chk.chk_req    = req_q;
  assign chk.chk_player = player_q;
  assign chk.plat_idx   = idx_q;
  assign col_p0_o       = col0_q;
  assign col_p1_o       = col1_q;
  assign update_p_o     = upd_q;
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = ovr_q;
  assign chk_err_o      = err_q;

endmodule

// File: tb/tb_physics_sequencer.sv
// Scoreboarded bench: a checker model answers requests, a monitor pops expected publishes.
module tb_physics_sequencer;
  import physics_sequencer_pkg::*;

  localparam int N_PLAT  = 4;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    int         cyc;
    logic [1:0] upd;
    hit_t       flags;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       clr_err = 1'b0;
  hit_t       col_p0;
  hit_t       col_p1;
  logic [1:0] update_p;
  logic       busy;
  logic       overrun;
  logic       chk_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  hit_t tbl [2][N_PLAT];
  int   ack_delay = 0;
  int   blk_player = -1;
  int   blk_idx = -1;
  logic stray_ack = 1'b0;

  ev_t exp_q [$];
  int  stab_viol = 0;
  int  gaps = 0;
  int  bad_gap = 0;

  physics_sequencer_if #(.IDX_W(IDX_W)) chk_if ();

  physics_sequencer #(
    .N_PLAT  (N_PLAT),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick_i (frame_tick),
    .clr_err_i    (clr_err),
    .chk          (chk_if),
    .col_p0_o     (col_p0),
    .col_p1_o     (col_p1),
    .update_p_o   (update_p),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .chk_err_o    (chk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collision checker model: answers after ack_delay wait cycles unless the target is blocked.
  initial begin : responder
    int wcnt;
    int p;
    int i;
    wcnt = 0;
    chk_if.chk_ack = 1'b0;
    chk_if.chk_hit = '0;
    forever begin
      @(negedge clk);
      p = int'(chk_if.chk_player);
      i = int'(chk_if.plat_idx);
      if (!chk_if.chk_req) begin
        wcnt = 0;
        chk_if.chk_ack = stray_ack;
        chk_if.chk_hit = 5'b11111;
      end else if (wcnt >= ack_delay && !(p == blk_player && i == blk_idx) && i < N_PLAT) begin
        chk_if.chk_ack = 1'b1;
        chk_if.chk_hit = tbl[p][i];
        wcnt = 0;
      end else begin
        chk_if.chk_ack = 1'b0;
        chk_if.chk_hit = 5'b11111;
        wcnt++;
      end
    end
  end

  initial begin : monitor
    ev_t  e;
    hit_t f;
    logic prev_req;
    logic prev_pl;
    logic [IDX_W-1:0] prev_idx;
    logic seen_req;
    int   low_run;
    prev_req = 1'b0;
    prev_pl = 1'b0;
    prev_idx = '0;
    seen_req = 1'b0;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (chk_if.chk_req && prev_req &&
          (chk_if.chk_player !== prev_pl || chk_if.plat_idx !== prev_idx)) stab_viol++;
      if (!busy) begin
        seen_req = 1'b0;
        low_run = 0;
      end else if (chk_if.chk_req) begin
        if (!prev_req && seen_req) begin
          gaps++;
          if (low_run != 1) bad_gap++;
        end
        seen_req = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = chk_if.chk_req;
      prev_pl = chk_if.chk_player;
      prev_idx = chk_if.plat_idx;

      if (update_p !== 2'b00) begin
        total++;
        f = update_p[1] ? col_p1 : col_p0;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_update cyc=%0d update_p=%b flags=%b", cyc, update_p, f);
        end else begin
          e = exp_q.pop_front();
          if (update_p !== e.upd || f !== e.flags || (e.cyc >= 0 && cyc != e.cyc)) begin
            bad++;
            $display("FAIL publish got upd=%b flags=%b cyc=%0d want upd=%b flags=%b cyc=%0d",
                     update_p, f, cyc, e.upd, e.flags, e.cyc);
          end
        end
      end
    end
  end

  task automatic clear_tbl();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N_PLAT; i++) tbl[p][i] = '0;
  endtask

  task automatic tick_frame(output int t0);
    @(negedge clk);
    frame_tick = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    fall = busy ? -1 : cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({chk_if.chk_req, chk_if.chk_player, chk_if.plat_idx} !== '0) begin
      bad++;
      $display("FAIL reset_handshake got req/pl/idx=%b/%b/%0d want 0", chk_if.chk_req,
               chk_if.chk_player, chk_if.plat_idx);
    end
    total++;
    if ({col_p0, col_p1, update_p} !== '0) begin
      bad++;
      $display("FAIL reset_flags got p0=%b p1=%b upd=%b want 0", col_p0, col_p1, update_p);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, overrun, chk_err, chk_if.chk_req} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_status got busy/ovr/err/req=%b%b%b%b want 0000", busy, overrun,
               chk_err, chk_if.chk_req);
    end
  endtask

  task automatic test_zero_wait();
    int t0;
    int fall;
    clear_tbl();
    tbl[1][2] = 5'b00011;
    ack_delay = 0;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b00000});
    exp_q.push_back('{t0 + 16, 2'b10, 5'b00011});
    total++;
    if (chk_if.chk_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL first_req got req=%b busy=%b want 1 1", chk_if.chk_req, busy);
    end
    wait_idle(200, fall);
    total++;
    if (fall != t0 + 17) begin
      bad++;
      $display("FAIL zw_busy_fall got cycle=%0d want %0d", fall - t0, 17);
    end
    total++;
    if (exp_q.size() != 0 || col_p0 !== 5'b00000 || col_p1 !== 5'b00011) begin
      bad++;
      $display("FAIL zw_result got pending=%0d p0=%b p1=%b want 0 00000 00011", exp_q.size(),
               col_p0, col_p1);
    end
  endtask

  task automatic test_delayed();
    int t0;
    int fall;
    clear_tbl();
    tbl[1][2] = 5'b00011;
    ack_delay = 3;
    stray_ack = 1'b1;
    stab_viol = 0;
    gaps = 0;
    bad_gap = 0;
    tick_frame(t0);
    exp_q.push_back('{t0 + 20, 2'b01, 5'b00000});
    exp_q.push_back('{t0 + 40, 2'b10, 5'b00011});
    wait_idle(400, fall);
    stray_ack = 1'b0;
    ack_delay = 0;
    total++;
    if (fall != t0 + 41) begin
      bad++;
      $display("FAIL dly_busy_fall got cycle=%0d want %0d", fall - t0, 41);
    end
    total++;
    if (stab_viol != 0) begin
      bad++;
      $display("FAIL dly_stable got changes=%0d want 0", stab_viol);
    end
    total++;
    if (gaps != 2 * N_PLAT - 1 || bad_gap != 0) begin
      bad++;
      $display("FAIL dly_gaps got gaps=%0d bad=%0d want %0d 0", gaps, bad_gap, 2 * N_PLAT - 1);
    end
    total++;
    if (exp_q.size() != 0 || col_p1 !== 5'b00011) begin
      bad++;
      $display("FAIL dly_result got pending=%0d p1=%b want 0 00011", exp_q.size(), col_p1);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int fall;
    clear_tbl();
    tbl[0][0] = 5'b00100;
    tbl[0][1] = 5'b10000;
    blk_player = 0;
    blk_idx = 1;
    tick_frame(t0);
    exp_q.push_back('{t0 + 71, 2'b01, 5'b00100});
    exp_q.push_back('{t0 + 79, 2'b10, 5'b00000});
    while (cyc < t0 + 66) @(negedge clk);
    total++;
    if (chk_err !== 1'b0 || chk_if.chk_req !== 1'b1 || chk_if.plat_idx !== 4'd1) begin
      bad++;
      $display("FAIL to_before got err=%b req=%b idx=%0d want 0 1 1", chk_err, chk_if.chk_req,
               chk_if.plat_idx);
    end
    @(negedge clk);
    total++;
    if (chk_err !== 1'b1 || chk_if.chk_req !== 1'b0) begin
      bad++;
      $display("FAIL to_expire got err=%b req=%b want 1 0", chk_err, chk_if.chk_req);
    end
    wait_idle(200, fall);
    blk_player = -1;
    blk_idx = -1;
    total++;
    if (fall != t0 + 80 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL to_done got fall=%0d pending=%0d want 80 0", fall - t0, exp_q.size());
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL to_clear got err=%b want 0", chk_err);
    end
  endtask

  task automatic test_overrun();
    int t0;
    int fall;
    clear_tbl();
    tbl[0][3] = 5'b01000;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b01000});
    exp_q.push_back('{t0 + 16, 2'b10, 5'b00000});
    while (cyc < t0 + 5) @(negedge clk);
    frame_tick = 1'b1;
    clr_err = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set got overrun=%b want 1", overrun);
    end
    wait_idle(200, fall);
    repeat (4) @(negedge clk);
    total++;
    if (fall != t0 + 17 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ovr_single got fall=%0d busy=%b pending=%0d want 17 0 0", fall - t0, busy,
               exp_q.size());
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear got overrun=%b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int fall;
    int n;
    clear_tbl();
    tbl[0][0] = 5'b00010;
    blk_player = 1;
    blk_idx = 3;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b00010});
    n = 0;
    while (!(chk_if.chk_req === 1'b1 && chk_if.chk_player === 1'b1 && chk_if.plat_idx === 4'd3)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (n >= 100 || col_p0 !== 5'b00010) begin
      bad++;
      $display("FAIL rst_reach got waited=%0d p0=%b want <100 00010", n, col_p0);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({chk_if.chk_req, busy, col_p0, col_p1, update_p} !== '0) begin
      bad++;
      $display("FAIL rst_mid got req=%b busy=%b p0=%b p1=%b upd=%b want all 0", chk_if.chk_req,
               busy, col_p0, col_p1, update_p);
    end
    @(negedge clk);
    reset = 1'b1;
    blk_player = -1;
    blk_idx = -1;
    tbl[1][1] = 5'b10100;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b00010});
    exp_q.push_back('{t0 + 16, 2'b10, 5'b10100});
    wait_idle(200, fall);
    total++;
    if (fall != t0 + 17 || exp_q.size() != 0 || col_p1 !== 5'b10100) begin
      bad++;
      $display("FAIL rst_fresh got fall=%0d pending=%0d p1=%b want 17 0 10100", fall - t0,
               exp_q.size(), col_p1);
    end
  endtask

  task automatic test_two_frames();
    int t0;
    int fall;
    clear_tbl();
    tbl[0][2] = 5'b00001;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b00001});
    exp_q.push_back('{t0 + 16, 2'b10, 5'b00000});
    wait_idle(200, fall);
    total++;
    if (col_p0 !== 5'b00001) begin
      bad++;
      $display("FAIL frame1_p0 got %b want 00001", col_p0);
    end
    tbl[0][2] = 5'b00000;
    tick_frame(t0);
    exp_q.push_back('{t0 + 8, 2'b01, 5'b00000});
    exp_q.push_back('{t0 + 16, 2'b10, 5'b00000});
    wait_idle(200, fall);
    total++;
    if (col_p0 !== 5'b00000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL frame2_p0 got %b pending=%0d want 00000 0", col_p0, exp_q.size());
    end
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    clear_tbl();
    test_reset();
    test_zero_wait();
    test_delayed();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_two_frames();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
